// File: rtl/softmax_norm.sv
// Softmax normalization back-end: buffers N exp words, accumulates their sum,
// then emits each element divided by the sum as saturating UQ0.16.
module softmax_norm #(
  parameter int N  = 8,
  parameter int QB = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [20:0] in_exp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prob,
  output logic        out_last
);

  localparam int IW = $clog2(N);
  localparam int SW = 32 + IW;   // sum of N 32-bit words cannot overflow
  localparam int RW = SW + 1;    // partial remainder is < 2*sum after the shift

  typedef enum logic [1:0] {ST_LOAD, ST_DIV, ST_HOLD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [SW-1:0]   sum_q;
  logic [RW-1:0]   rem_q;
  logic [QB-2:0]   q_q;
  logic [4:0]      bit_cnt_q;
  logic [31:0]     buf_mem [N];

  logic [4:0]      p_clamped;
  logic [31:0]     fx;
  logic            in_hs, out_hs, idx_last, div_done;
  logic            sum_nz, ge, q_bit;
  logic [RW-1:0]   diff, rem_next;
  logic [QB-1:0]   q_full;
  logic [15:0]     prob_sat;

  // Word decode: value = m * 2^(p-16), positions above 16 clamp to 16.
  assign p_clamped = (in_exp[20:16] > 5'd16) ? 5'd16 : in_exp[20:16];
  assign fx        = {16'h0000, in_exp[15:0]} << p_clamped;

  assign in_ready = (state_q == ST_LOAD);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign idx_last = (idx_q == IW'(N - 1));
  assign div_done = (state_q == ST_DIV) && (bit_cnt_q == 5'(QB - 1));

  // Restoring step: the remainder is pre-scaled so the first compare decides
  // the 2^16 bit; a zero divisor gates every quotient bit to 0.
  assign sum_nz   = (sum_q != '0);
  assign ge       = (rem_q >= RW'(sum_q));
  assign diff     = rem_q - RW'(sum_q);
  assign q_bit    = ge && sum_nz;
  assign rem_next = ge ? (diff << 1) : (rem_q << 1);
  assign q_full   = {q_q, q_bit};
  assign prob_sat = q_full[QB-1] ? 16'hFFFF : q_full[15:0];

  // NOTE: always_comb assigns every output a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (in_hs && idx_last) state_d = ST_DIV;
      ST_DIV:  if (div_done)          state_d = ST_HOLD;
      ST_HOLD: if (out_hs)            state_d = idx_last ? ST_LOAD : ST_DIV;
      default:                        state_d = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  // NOTE: the vector buffer has no reset; each slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_hs) buf_mem[idx_q] <= fx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      sum_q     <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      bit_cnt_q <= '0;
      out_valid <= 1'b0;
      out_prob  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_hs) begin
            sum_q <= sum_q + SW'(fx);
            if (idx_last) begin
              // Slot 0 was written on an earlier edge since N >= 2.
              idx_q     <= '0;
              rem_q     <= RW'(buf_mem[0]);
              bit_cnt_q <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_DIV: begin
          rem_q     <= rem_next;
          q_q       <= q_full[QB-2:0];
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (div_done) begin
            out_valid <= 1'b1;
            out_prob  <= prob_sat;
            out_last  <= idx_last;
          end
        end
        ST_HOLD: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            if (idx_last) begin
              idx_q <= '0;
              sum_q <= '0;
            end else begin
              idx_q     <= idx_q + 1'b1;
              rem_q     <= RW'(buf_mem[idx_q + 1'b1]);
              bit_cnt_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_norm.sv
// Directed self-checking bench for softmax_norm with N = 4.
module tb_softmax_norm;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [20:0] in_exp = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_last;
  logic [15:0] out_prob;

  int vectors = 0;
  int miscompares = 0;

  softmax_norm #(.N(N), .QB(17)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prob  (out_prob),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] w(input int p, input int m);
    return {p[4:0], m[15:0]};
  endfunction

  task automatic send4(input string tag, input logic [20:0] a, b, c, d);
    logic [20:0] ws [4];
    ws = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_exp   = ws[i];
      check($sformatf("%s in_ready%0d", tag, i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Waits for a probability, checks latency/value/last, optionally stalls, then accepts it.
  task automatic get_out(input string tag, input logic [15:0] exp_prob, input logic exp_last,
                         input int hold);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd17);
    check({tag, " prob"}, 32'(out_prob), 32'(exp_prob));
    check({tag, " last"}, 32'(out_last), 32'(exp_last));
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      in_exp   = w(16, 16'hFFFF);
      @(posedge clk); #1;
      check($sformatf("%s hold%0d prob", tag, i), 32'(out_prob), 32'(exp_prob));
      check($sformatf("%s hold%0d last", tag, i), 32'(out_last), 32'(exp_last));
      check($sformatf("%s hold%0d valid", tag, i), 32'(out_valid), 32'd1);
      check($sformatf("%s hold%0d in_ready", tag, i), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, " rst valid"}, 32'(out_valid), 32'd0);
    check({tag, " rst prob"}, 32'(out_prob), 32'd0);
    check({tag, " rst last"}, 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check({tag, " in_ready after rst"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    #12;
    reset_pulse("init");

    // Uniform vector
    send4("t1", w(16, 1), w(16, 1), w(16, 1), w(16, 1));
    get_out("t1_0", 16'h4000, 1'b0, 0);
    get_out("t1_1", 16'h4000, 1'b0, 0);
    get_out("t1_2", 16'h4000, 1'b0, 0);
    get_out("t1_3", 16'h4000, 1'b1, 0);
    check("t1 in_ready back", 32'(in_ready), 32'd1);

    // Saturation: element equals the sum
    send4("t2", w(16, 1), w(0, 0), w(0, 0), w(0, 0));
    get_out("t2_0", 16'hFFFF, 1'b0, 0);
    get_out("t2_1", 16'h0000, 1'b0, 0);
    get_out("t2_2", 16'h0000, 1'b0, 0);
    get_out("t2_3", 16'h0000, 1'b1, 0);

    // All zero
    send4("t3", w(16, 0), w(3, 0), w(20, 0), w(0, 0));
    get_out("t3_0", 16'h0000, 1'b0, 0);
    get_out("t3_1", 16'h0000, 1'b0, 0);
    get_out("t3_2", 16'h0000, 1'b0, 0);
    get_out("t3_3", 16'h0000, 1'b1, 0);

    // Backpressure with in_valid pulses that must not be absorbed
    send4("t4", w(16, 1), w(16, 2), w(16, 1), w(16, 0));
    get_out("t4_0", 16'h4000, 1'b0, 10);
    get_out("t4_1", 16'h8000, 1'b0, 0);
    get_out("t4_2", 16'h4000, 1'b0, 0);
    get_out("t4_3", 16'h0000, 1'b1, 10);

    // Position clamp: p=20 behaves as p=16
    send4("t5a", w(20, 3), w(16, 1), w(0, 0), w(0, 0));
    get_out("t5a_0", 16'hC000, 1'b0, 0);
    get_out("t5a_1", 16'h4000, 1'b0, 0);
    get_out("t5a_2", 16'h0000, 1'b0, 0);
    get_out("t5a_3", 16'h0000, 1'b1, 0);
    send4("t5b", w(16, 3), w(16, 1), w(0, 0), w(0, 0));
    get_out("t5b_0", 16'hC000, 1'b0, 0);
    get_out("t5b_1", 16'h4000, 1'b0, 0);
    get_out("t5b_2", 16'h0000, 1'b0, 0);
    get_out("t5b_3", 16'h0000, 1'b1, 0);

    // Mixed positions summing to 3 * 0x10000
    send4("t5c", w(16, 1), w(15, 2), w(14, 4), w(16, 0));
    get_out("t5c_0", 16'h5555, 1'b0, 0);
    get_out("t5c_1", 16'h5555, 1'b0, 0);
    get_out("t5c_2", 16'h5555, 1'b0, 0);
    get_out("t5c_3", 16'h0000, 1'b1, 0);

    // Reset while holding a probability clears the outputs asynchronously
    send4("t6a", w(16, 1), w(16, 1), w(16, 1), w(16, 1));
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t6a latency", 32'(lat), 32'd17);
    check("t6a prob", 32'(out_prob), 32'h4000);
    reset_pulse("t6a");

    // Reset after two words discards the partial vector
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_exp   = w(16, 16'hFFFF);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset_pulse("t6b");
    send4("t6", w(16, 1), w(16, 1), w(16, 1), w(16, 1));
    get_out("t6_0", 16'h4000, 1'b0, 0);
    get_out("t6_1", 16'h4000, 1'b0, 0);
    get_out("t6_2", 16'h4000, 1'b0, 0);
    get_out("t6_3", 16'h4000, 1'b1, 0);
    check("t6 in_ready back", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
